spi_slave_axis: RTL and testbench

// SPI slave (mode 0, MSB first) that converts host SPI transactions into byte frames for the SoC

---
 rtl/spi_slave_axis_if.sv | 26 ++
 rtl/spi_slave_axis.sv | 144 ++++++++++++++
 tb/tb_spi_slave_axis.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_axis_if.sv
// Byte-stream handshake bundle between the SPI slave and the SoC command path.
// The slave modport is the SPI side; master is the command/response side.
interface spi_slave_axis_if;
  logic [7:0] output_axis_tdata;
  logic       output_axis_tvalid;
  logic       output_axis_tready;
  logic       output_axis_tlast;
  logic [7:0] input_axis_tdata;
  logic       input_axis_tvalid;
  logic       input_axis_tready;
  logic       input_axis_tlast;

  modport slave (
    output output_axis_tdata, output_axis_tvalid, output_axis_tlast,
    input  output_axis_tready,
    input  input_axis_tdata, input_axis_tvalid, input_axis_tlast,
    output input_axis_tready
  );

  modport master (
    input  output_axis_tdata, output_axis_tvalid, output_axis_tlast,
    output output_axis_tready,
    output input_axis_tdata, input_axis_tvalid, input_axis_tlast,
    input  input_axis_tready
  );
endinterface

// File: rtl/spi_slave_axis.sv
// SPI mode-0 slave: MOSI bytes become framed stream beats (CS_n low = one frame),
// response stream bytes are shifted out on MISO, MSB first.
module spi_slave_axis #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_FILL   = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            spi_sck_i,
  input  logic            spi_cs_n_i,
  input  logic            spi_mosi_i,
  output logic            spi_miso_o,
  output logic            spi_miso_oe_o,
  spi_slave_axis_if.slave axis,
  output logic            overflow_o,
  output logic            busy_o
);

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;

  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] held_q, held_d;
  logic       held_valid_q, held_valid_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       overflow_q, overflow_d;

  logic       sck_rise, sck_fall, cs_fall, cs_rise, cs_act, cs_idle, mosi_s;
  logic       tx_load_evt;
  logic [7:0] tx_next_byte, rx_next;
  logic       push;
  logic [7:0] push_data;
  logic       push_last;
  logic       unused_tlast;

  // Edges come from the two oldest synchronizer stages; MOSI is taken from the
  // oldest stage, which is stable around a rising SCK.
  assign sck_rise = sck_sync_q[SYNC_STAGES-2] & ~sck_sync_q[SYNC_STAGES-1];
  assign sck_fall = ~sck_sync_q[SYNC_STAGES-2] & sck_sync_q[SYNC_STAGES-1];
  assign cs_fall  = cs_sync_q[SYNC_STAGES-1] & ~cs_sync_q[SYNC_STAGES-2];
  assign cs_rise  = ~cs_sync_q[SYNC_STAGES-1] & cs_sync_q[SYNC_STAGES-2];
  assign cs_act   = ~cs_sync_q[SYNC_STAGES-1] & ~cs_sync_q[SYNC_STAGES-2];
  assign cs_idle  = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];

  assign rx_next      = {rx_shift_q[6:0], mosi_s};
  assign tx_load_evt  = cs_fall | (cs_act & sck_fall & (bit_cnt_q == 3'd0));
  assign tx_next_byte = axis.input_axis_tvalid ? axis.input_axis_tdata : IDLE_FILL;

  assign axis.input_axis_tready = ~rst & (cs_idle | (tx_load_evt & axis.input_axis_tvalid));
  assign unused_tlast           = axis.input_axis_tlast;

  assign axis.output_axis_tdata  = out_data_q;
  assign axis.output_axis_tvalid = out_valid_q;
  assign axis.output_axis_tlast  = out_last_q;
  assign overflow_o              = overflow_q;
  assign busy_o                  = ~cs_idle;
  assign spi_miso_oe_o           = ~cs_idle;
  assign spi_miso_o              = ~cs_idle & tx_shift_q[7];

  always_comb begin
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    held_d       = held_q;
    held_valid_d = held_valid_q;
    bit_cnt_d    = bit_cnt_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q & ~axis.output_axis_tready;
    overflow_d   = 1'b0;
    push         = 1'b0;
    push_data    = held_q;
    push_last    = 1'b0;

    // A byte is only emitted once the next one completes or CS rises, so the
    // final byte of the frame can carry tlast.
    if (cs_fall) begin
      bit_cnt_d    = '0;
      held_valid_d = 1'b0;
      tx_shift_d   = tx_next_byte;
    end else if (cs_rise) begin
      push         = held_valid_q;
      push_last    = 1'b1;
      held_valid_d = 1'b0;
    end else if (cs_act) begin
      if (sck_rise) begin
        rx_shift_d = rx_next;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          push         = held_valid_q;
          held_d       = rx_next;
          held_valid_d = 1'b1;
        end
      end
      if (sck_fall) begin
        tx_shift_d = (bit_cnt_q == 3'd0) ? tx_next_byte : {tx_shift_q[6:0], 1'b0};
      end
    end

    if (push) begin
      if (!out_valid_q || axis.output_axis_tready) begin
        out_data_d  = push_data;
        out_last_d  = push_last;
        out_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q   <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      held_q       <= '0;
      held_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      held_q       <= held_d;
      held_valid_q <= held_valid_d;
      bit_cnt_q    <= bit_cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_spi_slave_axis.sv
// Directed and randomized frames against a byte-level model of the SPI slave:
// MOSI bytes -> framed beats, queued response bytes -> MISO bytes.
module tb_spi_slave_axis;
  localparam logic [7:0] FILL = 8'h00;

  logic clk = 1'b0;
  logic rst, sck, cs_n, mosi, miso, miso_oe, overflow, busy;

  spi_slave_axis_if ax ();

  spi_slave_axis #(.SYNC_STAGES(2), .IDLE_FILL(FILL)) dut (
    .clk           (clk),
    .rst           (rst),
    .spi_sck_i     (sck),
    .spi_cs_n_i    (cs_n),
    .spi_mosi_i    (mosi),
    .spi_miso_o    (miso),
    .spi_miso_oe_o (miso_oe),
    .axis          (ax),
    .overflow_o    (overflow),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_resp[$];
  logic [7:0] mosi_q[$];
  logic [7:0] miso_got[$];
  logic [8:0] got_q[$];
  bit          src_en;
  bit          hs_pend = 1'b0;
  int unsigned hs_cnt = 0;
  int unsigned hs_start, hs_frame;
  int unsigned ovf_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic src_drive();
    if (src_en && src_q.size() != 0) begin
      ax.input_axis_tvalid = 1'b1;
      ax.input_axis_tdata  = src_q[0];
    end else begin
      ax.input_axis_tvalid = 1'b0;
      ax.input_axis_tdata  = 8'h00;
    end
  endtask

  // Response source: pops on each accepted byte. Sink monitor logs accepted beats.
  always @(negedge clk) begin
    hs_pend = ax.input_axis_tvalid & ax.input_axis_tready;
    if (ax.output_axis_tvalid && ax.output_axis_tready)
      got_q.push_back({ax.output_axis_tlast, ax.output_axis_tdata});
    if (overflow) ovf_cnt++;
  end

  always @(posedge clk) begin
    #1;
    if (hs_pend) begin
      if (src_q.size() != 0) void'(src_q.pop_front());
      hs_cnt++;
    end
    src_drive();
  end

  task automatic spi_frame(input int unsigned nbits);
    logic [7:0] b, cur;
    miso_got.delete();
    hs_start = hs_cnt;
    cur = '0;
    cs_n = 1'b0;
    step(1);
    src_en = 1'b1;
    src_drive();
    step(3);
    chk("busy_in_frame", busy, 1);
    chk("miso_oe_in_frame", miso_oe, 1);
    for (int unsigned i = 0; i < nbits; i++) begin
      b = mosi_q[i / 8];
      mosi = b[7 - (i % 8)];
      step(4);
      cur = {cur[6:0], miso};
      sck = 1'b1;
      step(4);
      sck = 1'b0;
      if (i % 8 == 7) miso_got.push_back(cur);
    end
    step(4);
    hs_frame = hs_cnt - hs_start;
    cs_n = 1'b1;
    mosi = 1'b0;
    step(6);
    chk("busy_after_frame", busy, 0);
  endtask

  task automatic run_frame(input int unsigned nbits, input bit check_rx);
    int unsigned nfull, ntake;
    logic [7:0] eb;
    nfull = nbits / 8;
    ntake = (exp_resp.size() < nfull + 1) ? exp_resp.size() : nfull + 1;
    got_q.delete();
    ovf_cnt = 0;
    src_en = 1'b0;
    src_q = exp_resp;
    src_drive();
    spi_frame(nbits);
    step(6);
    chk("miso_cnt", miso_got.size(), nfull);
    for (int unsigned k = 0; k < nfull && k < miso_got.size(); k++) begin
      eb = (k < exp_resp.size()) ? exp_resp[k] : FILL;
      chk("miso_byte", miso_got[k], eb);
    end
    chk("resp_taken", hs_frame, ntake);
    chk("resp_drained", src_q.size(), 0);
    if (check_rx) begin
      chk("beat_cnt", got_q.size(), nfull);
      for (int unsigned k = 0; k < nfull && k < got_q.size(); k++) begin
        eb = mosi_q[k];
        chk("beat", got_q[k], {(k == nfull - 1), eb});
      end
      chk("overflow_cnt", ovf_cnt, 0);
    end
  endtask

  initial begin
    int unsigned n, extra, nr, hs0;
    rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; src_en = 1'b0;
    ax.output_axis_tready = 1'b1;
    ax.input_axis_tlast = 1'b0;
    src_drive();
    step(3);
    chk("rst_tvalid", ax.output_axis_tvalid, 0);
    chk("rst_tdata", ax.output_axis_tdata, 0);
    chk("rst_tlast", ax.output_axis_tlast, 0);
    chk("rst_in_tready", ax.input_axis_tready, 0);
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step(2);
    chk("idle_in_tready", ax.input_axis_tready, 1);

    // Frame A5,00,12 with no response queued.
    mosi_q = '{8'hA5, 8'h00, 8'h12};
    exp_resp.delete();
    run_frame(24, 1);

    // Preloaded response 01,3C on a 4-byte frame.
    mosi_q = '{8'h3A, 8'hC5, 8'h0F, 8'hF0};
    exp_resp = '{8'h01, 8'h3C};
    run_frame(32, 1);

    // One byte plus three bits: partial bits dropped.
    mosi_q = '{8'h96, 8'hE0};
    exp_resp.delete();
    run_frame(11, 1);

    // Sink stalled: slot keeps the first byte, later pushes are dropped.
    ax.output_axis_tready = 1'b0;
    mosi_q = '{8'hC1, 8'hC2, 8'hC3};
    exp_resp.delete();
    run_frame(24, 0);
    chk("stall_overflow_pulses", ovf_cnt, 2);
    chk("stall_beats", got_q.size(), 0);
    chk("stall_tvalid", ax.output_axis_tvalid, 1);
    chk("stall_tdata", ax.output_axis_tdata, 8'hC1);
    ax.output_axis_tready = 1'b1;
    step(3);
    chk("stall_release_cnt", got_q.size(), 1);
    if (got_q.size() != 0) chk("stall_release_beat", got_q[0], {1'b0, 8'hC1});
    chk("stall_tvalid_clear", ax.output_axis_tvalid, 0);

    // Stale response bytes drained while CS idle.
    src_q = '{8'h55, 8'hAA};
    hs0 = hs_cnt;
    src_en = 1'b1;
    src_drive();
    step(5);
    chk("idle_drain_cnt", hs_cnt - hs0, 2);
    chk("idle_drain_empty", src_q.size(), 0);
    mosi_q = '{8'h11, 8'h22};
    exp_resp.delete();
    run_frame(16, 1);

    // Reset in the middle of a byte.
    cs_n = 1'b0;
    step(4);
    mosi = 1'b1;
    sck = 1'b1;
    step(4);
    sck = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    chk("midrst_tvalid", ax.output_axis_tvalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_miso", miso, 0);
    chk("midrst_miso_oe", miso_oe, 0);
    chk("midrst_overflow", overflow, 0);
    cs_n = 1'b1;
    mosi = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);
    mosi_q = '{8'h7E};
    exp_resp.delete();
    run_frame(8, 1);

    // Random frames, random response queues, some with trailing partial bits.
    for (int unsigned r = 0; r < 8; r++) begin
      n = $urandom_range(0, 4);
      extra = (r % 2 == 1) ? $urandom_range(1, 7) : 0;
      mosi_q.delete();
      for (int unsigned k = 0; k <= n; k++) mosi_q.push_back(8'($urandom));
      exp_resp.delete();
      nr = $urandom_range(0, 5);
      for (int unsigned k = 0; k < nr; k++) exp_resp.push_back(8'($urandom));
      run_frame(n * 8 + extra, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
